// File: rtl/mem_test.sv
// Cache/memory exerciser: 8-byte backing RAM, 4-line fully associative
// write-through cache with true LRU ages, driven by an address-sweep sequencer.
module mem_test (
  input  logic       clk,
  input  logic       clr,
  input  logic       rw,
  input  logic       enab,
  output logic [7:0] data_out,
  output logic       hit,
  output logic [7:0] addr0,
  output logic [7:0] addr1,
  output logic [7:0] addr2,
  output logic [7:0] addr3,
  output logic [7:0] data0,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [7:0] data3,
  output logic [7:0] ram0,
  output logic [7:0] ram1,
  output logic [7:0] ram2,
  output logic [7:0] ram3,
  output logic [7:0] ram4,
  output logic [7:0] ram5,
  output logic [7:0] ram6,
  output logic [7:0] ram7,
  output logic [3:0] state,
  output logic [7:0] cache_addr,
  output logic [7:0] cache_data,
  output logic [2:0] i_out,
  output logic       cache_clr,
  output logic       cache_enab,
  output logic       cache_rw,
  output logic [1:0] cache_lru,
  output logic [1:0] cache_hit
);

  localparam int unsigned DW    = 8;
  localparam int unsigned WORDS = 8;
  localparam int unsigned LINES = 4;
  localparam int unsigned IW    = 3;
  localparam int unsigned LW    = 2;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ISSUE  = 4'd1;
  localparam logic [3:0] S_LOOKUP = 4'd2;
  localparam logic [3:0] S_FILL   = 4'd3;
  localparam logic [3:0] S_UPDATE = 4'd4;

  logic [3:0]    state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [DW-1:0] ram_q  [WORDS];
  logic [DW-1:0] ram_d  [WORDS];
  logic [DW-1:0] tag_q  [LINES];
  logic [DW-1:0] tag_d  [LINES];
  logic [DW-1:0] line_q [LINES];
  logic [DW-1:0] line_d [LINES];
  logic [LW-1:0] age_q  [LINES];
  logic [LW-1:0] age_d  [LINES];
  logic [DW-1:0] dout_q, dout_d;
  logic          hit_q, hit_d;
  logic [LW-1:0] hidx_q, hidx_d;
  logic          rw_q, rw_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          touch_q, touch_d;
  logic [LW-1:0] tidx_q, tidx_d;
  logic          enab_q, enab_d;

  logic [LW-1:0] lru_c;
  logic          match_c;
  logic [LW-1:0] match_idx_c;

  // LRU line is the one whose age has reached the maximum
  always_comb begin
    lru_c = '0;
    for (int k = 0; k < LINES; k++) begin
      if (age_q[k] == 2'd3) lru_c = LW'(k);
    end
  end

  // Full 8-bit tag compare; invalid tag 8'hFF can never equal {5'b0, i}
  always_comb begin
    match_c     = 1'b0;
    match_idx_c = '0;
    for (int k = 0; k < LINES; k++) begin
      if (tag_q[k] == addr_q) begin
        match_c     = 1'b1;
        match_idx_c = LW'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    ram_d   = ram_q;
    tag_d   = tag_q;
    line_d  = line_q;
    age_d   = age_q;
    dout_d  = dout_q;
    hit_d   = hit_q;
    hidx_d  = hidx_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    touch_d = touch_q;
    tidx_d  = tidx_q;

    case (state_q)
      S_IDLE: begin
        if (enab) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        rw_d    = rw;
        addr_d  = {5'b0, i_q};
        wdata_d = 8'hA0 + {5'b0, i_q};
        touch_d = 1'b0;
        state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        hit_d  = match_c;
        hidx_d = match_c ? match_idx_c : '0;
        if (rw_q) begin
          ram_d[i_q] = wdata_q;
          if (match_c) begin
            line_d[match_idx_c] = wdata_q;
            touch_d = 1'b1;
            tidx_d  = match_idx_c;
          end
          state_d = S_UPDATE;
        end else if (match_c) begin
          dout_d  = line_q[match_idx_c];
          touch_d = 1'b1;
          tidx_d  = match_idx_c;
          state_d = S_UPDATE;
        end else begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        tag_d[lru_c]  = addr_q;
        line_d[lru_c] = ram_q[i_q];
        dout_d        = ram_q[i_q];
        touch_d       = 1'b1;
        tidx_d        = lru_c;
        state_d       = S_UPDATE;
      end
      S_UPDATE: begin
        // Younger lines than the touched one age by one; touched becomes MRU
        if (touch_q) begin
          for (int k = 0; k < LINES; k++) begin
            if (LW'(k) == tidx_q) begin
              age_d[k] = '0;
            end else if (age_q[k] < age_q[tidx_q]) begin
              age_d[k] = age_q[k] + 2'd1;
            end
          end
        end
        i_d     = i_q + 3'd1;
        state_d = enab ? S_ISSUE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    enab_d = (state_d == S_ISSUE) || (state_d == S_LOOKUP) || (state_d == S_FILL);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      for (int k = 0; k < WORDS; k++) ram_q[k] <= DW'(k * 17);
      for (int k = 0; k < LINES; k++) begin
        tag_q[k]  <= 8'hFF;
        line_q[k] <= '0;
        age_q[k]  <= LW'(3 - k);
      end
      dout_q  <= '0;
      hit_q   <= 1'b0;
      hidx_q  <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'hA0;
      touch_q <= 1'b0;
      tidx_q  <= '0;
      enab_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      ram_q   <= ram_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      age_q   <= age_d;
      dout_q  <= dout_d;
      hit_q   <= hit_d;
      hidx_q  <= hidx_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      touch_q <= touch_d;
      tidx_q  <= tidx_d;
      enab_q  <= enab_d;
    end
  end

  assign data_out   = dout_q;
  assign hit        = hit_q;
  assign addr0      = tag_q[0];
  assign addr1      = tag_q[1];
  assign addr2      = tag_q[2];
  assign addr3      = tag_q[3];
  assign data0      = line_q[0];
  assign data1      = line_q[1];
  assign data2      = line_q[2];
  assign data3      = line_q[3];
  assign ram0       = ram_q[0];
  assign ram1       = ram_q[1];
  assign ram2       = ram_q[2];
  assign ram3       = ram_q[3];
  assign ram4       = ram_q[4];
  assign ram5       = ram_q[5];
  assign ram6       = ram_q[6];
  assign ram7       = ram_q[7];
  assign state      = state_q;
  assign cache_addr = addr_q;
  assign cache_data = wdata_q;
  assign i_out      = i_q;
  assign cache_clr  = clr;
  assign cache_enab = enab_q;
  assign cache_rw   = rw_q;
  assign cache_lru  = lru_c;
  assign cache_hit  = hidx_q;

endmodule

// File: tb/tb_mem_test.sv
// Directed bench for mem_test: a reference cache model pushes expected access
// results into a scoreboard queue, popped and checked when the DUT reaches UPDATE.
module tb_mem_test;

  logic       clk = 1'b0;
  logic       clr, rw, enab;
  logic [7:0] data_out;
  logic       hit;
  logic [7:0] addr0, addr1, addr2, addr3, data0, data1, data2, data3;
  logic [7:0] ram0, ram1, ram2, ram3, ram4, ram5, ram6, ram7;
  logic [3:0] state;
  logic [7:0] cache_addr, cache_data;
  logic [2:0] i_out;
  logic       cache_clr, cache_enab, cache_rw;
  logic [1:0] cache_lru, cache_hit;

  mem_test dut (
    .clk(clk), .clr(clr), .rw(rw), .enab(enab),
    .data_out(data_out), .hit(hit),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .ram0(ram0), .ram1(ram1), .ram2(ram2), .ram3(ram3),
    .ram4(ram4), .ram5(ram5), .ram6(ram6), .ram7(ram7),
    .state(state), .cache_addr(cache_addr), .cache_data(cache_data),
    .i_out(i_out), .cache_clr(cache_clr), .cache_enab(cache_enab),
    .cache_rw(cache_rw), .cache_lru(cache_lru), .cache_hit(cache_hit)
  );

  always #5 clk = ~clk;

  logic [7:0] b_tag [4];
  logic [7:0] b_data[4];
  logic [7:0] b_ram [8];
  assign b_tag[0] = addr0;  assign b_tag[1] = addr1;
  assign b_tag[2] = addr2;  assign b_tag[3] = addr3;
  assign b_data[0] = data0; assign b_data[1] = data1;
  assign b_data[2] = data2; assign b_data[3] = data3;
  assign b_ram[0] = ram0; assign b_ram[1] = ram1; assign b_ram[2] = ram2; assign b_ram[3] = ram3;
  assign b_ram[4] = ram4; assign b_ram[5] = ram5; assign b_ram[6] = ram6; assign b_ram[7] = ram7;

  typedef struct {
    logic [2:0] idx;
    logic       hit;
    logic [1:0] hidx;
    logic [7:0] dout;
    logic [1:0] lru;
    logic       rw;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  logic [7:0] m_tag [4];
  logic [7:0] m_data[4];
  logic [7:0] m_ram [8];
  logic [1:0] m_age [4];
  logic [7:0] m_dout;
  logic [2:0] m_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_ram[k] = 8'(k * 17);
    for (int k = 0; k < 4; k++) begin
      m_tag[k]  = 8'hFF;
      m_data[k] = 8'h00;
      m_age[k]  = 2'(3 - k);
    end
    m_dout = 8'h00;
    m_i    = 3'd0;
  endtask

  // Apply one access to the model and queue its expected observable result
  task automatic model_access(input logic wr);
    exp_t       e;
    logic       h;
    logic [1:0] hx, lru, tix, ta;
    logic       touched;
    logic [7:0] a;
    h = 1'b0; hx = '0; lru = '0; tix = '0; touched = 1'b0;
    a = {5'b0, m_i};
    for (int k = 0; k < 4; k++) if (m_age[k] == 2'd3) lru = 2'(k);
    for (int k = 0; k < 4; k++) if (m_tag[k] == a) begin h = 1'b1; hx = 2'(k); end
    if (!wr) begin
      if (h) begin
        m_dout = m_data[hx]; touched = 1'b1; tix = hx;
      end else begin
        m_tag[lru] = a; m_data[lru] = m_ram[m_i]; m_dout = m_ram[m_i];
        touched = 1'b1; tix = lru;
      end
    end else begin
      m_ram[m_i] = 8'hA0 + a;
      if (h) begin
        m_data[hx] = 8'hA0 + a; touched = 1'b1; tix = hx;
      end
    end
    if (touched) begin
      ta = m_age[tix];
      for (int k = 0; k < 4; k++) begin
        if (2'(k) == tix) m_age[k] = 2'd0;
        else if (m_age[k] < ta) m_age[k] = m_age[k] + 2'd1;
      end
    end
    e.idx = m_i; e.hit = h; e.hidx = h ? hx : 2'd0; e.dout = m_dout; e.lru = lru; e.rw = wr;
    sb.push_back(e);
    m_i = m_i + 3'd1;
  endtask

  task automatic wait_state(input logic [3:0] code, input string tag);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (state == code) seen = 1'b1;
    end
    chk({tag, "_reached"}, 32'(seen), 32'd1);
  endtask

  task automatic check_update();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("i_out_at_%0d", e.idx), 32'(i_out), 32'(e.idx));
      chk($sformatf("hit_at_%0d", e.idx), 32'(hit), 32'(e.hit));
      chk($sformatf("cache_hit_at_%0d", e.idx), 32'(cache_hit), 32'(e.hidx));
      chk($sformatf("data_out_at_%0d", e.idx), 32'(data_out), 32'(e.dout));
      chk($sformatf("lru_at_%0d", e.idx), 32'(cache_lru), 32'(e.lru));
      chk($sformatf("cache_rw_at_%0d", e.idx), 32'(cache_rw), 32'(e.rw));
      chk($sformatf("cache_enab_at_%0d", e.idx), 32'(cache_enab), 32'd0);
    end
  endtask

  task automatic run_access(input logic wr);
    rw = wr;
    model_access(wr);
    wait_state(4'd4, "update");
    check_update();
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_state"}, 32'(state), 32'd0);
    chk({pfx, "_i_out"}, 32'(i_out), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_tag%0d", pfx, k), 32'(b_tag[k]), 32'hFF);
      chk($sformatf("%s_data%0d", pfx, k), 32'(b_data[k]), 32'h00);
    end
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_ram%0d", pfx, k), 32'(b_ram[k]), 32'(k * 17));
    chk({pfx, "_lru"}, 32'(cache_lru), 32'd0);
    chk({pfx, "_hit"}, 32'(hit), 32'd0);
    chk({pfx, "_cache_hit"}, 32'(cache_hit), 32'd0);
    chk({pfx, "_data_out"}, 32'(data_out), 32'd0);
    chk({pfx, "_cache_rw"}, 32'(cache_rw), 32'd0);
    chk({pfx, "_cache_clr"}, 32'(cache_clr), 32'd1);
  endtask

  initial begin
    clr = 1'b1; rw = 1'b0; enab = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");

    // Read sweep: all miss, fills lines 0..3 then evicts them in order
    clr = 1'b0; enab = 1'b1;
    model_reset();
    for (int n = 0; n < 8; n++) run_access(1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rd_tag%0d", k), 32'(b_tag[k]), 32'(4 + k));
      chk($sformatf("rd_data%0d", k), 32'(b_data[k]), 32'(8'h44 + 8'(k * 17)));
    end
    chk("rd_data_out", 32'(data_out), 32'h77);
    rw = 1'b1;
    @(negedge clk);
    chk("rd_i_wrap", 32'(i_out), 32'd0);

    // Write sweep: 0..3 write-miss (no allocate), 4..7 hit lines 0..3
    for (int n = 0; n < 8; n++) run_access(1'b1);
    for (int k = 0; k < 8; k++)
      chk($sformatf("wr_ram%0d", k), 32'(b_ram[k]), 32'(8'hA0 + 8'(k)));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wr_tag%0d", k), 32'(b_tag[k]), 32'(4 + k));
      chk($sformatf("wr_data%0d", k), 32'(b_data[k]), 32'(8'hA4 + 8'(k)));
    end

    // Re-read 0..3: misses evict LRU-first, data from written RAM
    for (int n = 0; n < 4; n++) run_access(1'b0);
    chk("rr_data_out", 32'(data_out), 32'hA3);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_tag%0d", k), 32'(b_tag[k]), 32'(k));

    // Drop enab during LOOKUP: access completes, FSM parks in IDLE
    rw = 1'b0;
    model_access(1'b0);
    wait_state(4'd2, "lookup");
    enab = 1'b0;
    wait_state(4'd4, "gate_update");
    check_update();
    @(negedge clk);
    chk("gate_state", 32'(state), 32'd0);
    chk("gate_i", 32'(i_out), 32'd5);
    repeat (3) @(negedge clk);
    chk("gate_state_hold", 32'(state), 32'd0);
    enab = 1'b1;
    run_access(1'b0);

    // Reset mid-FILL of the next read miss
    rw = 1'b0;
    wait_state(4'd3, "fill");
    clr = 1'b1;
    #1;
    check_reset_values("midfill");
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    run_access(1'b0);
    chk("restart_ram0", 32'(ram0), 32'h00);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
